// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: front end for the memory block.
// Buffers read/write requests in a small FIFO, issues them one at a time on
// the memory pins, waits for the memory's completion pulse (or a cycle-count
// timeout) and returns status and read data on a valid/ready response stream.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_write/req_addr/req_wdata : request stream in
//   rsp_valid/rsp_ready/rsp_write/rsp_rdata/rsp_err  : response stream out
//   mem_wr/mem_rd/mem_addr/mem_wdata                 : memory command out
//   mem_rdata/mem_response                           : memory completion in
//   busy                                             : FSM active or FIFO holds work
module mem_req_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_response,
    output logic              busy
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT);
    localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    // ---------------- request FIFO ----------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] head;

    assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head      = fifo_mem[rd_ptr_q];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_write, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are power-of-2 wide, so they wrap on their own.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
            else if (pop && !push) count_q <= count_q - (PTR_W+1)'(1);
        end
    end

    // ---------------- sequencing FSM ----------------
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_wr_d    = mem_wr_q;
        mem_rd_d    = mem_rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop         = 1'b1;
                    rsp_write_d = head[ENTRY_W-1];
                    mem_addr_d  = head[DATA_W +: ADDR_W];
                    mem_wdata_d = head[DATA_W-1:0];
                    mem_wr_d    = head[ENTRY_W-1];
                    mem_rd_d    = !head[ENTRY_W-1];
                    cnt_d       = '0;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Response is checked first so it wins over a coincident timeout.
                if (mem_response) begin
                    rsp_rdata_d = rsp_write_q ? '0 : mem_rdata;
                    rsp_err_d   = 1'b0;
                    mem_wr_d    = 1'b0;
                    mem_rd_d    = 1'b0;
                    state_d     = StResp;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_rd_d    = 1'b0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed testbench for mem_req_sequencer. A small memory model answers
// strobes after a fixed latency; timeout tests switch to manual response.
module tb_mem_req_sequencer;

    logic        clk, reset;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_wr, mem_rd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_response, busy;

    // Memory model / manual response control
    logic        mem_auto;
    int          mem_lat;
    logic        model_resp, man_resp;
    logic [31:0] model_rdata, man_rdata;
    logic [31:0] mem_model [256];

    int n_checks = 0;
    int n_fail   = 0;

    assign mem_response = mem_auto ? model_resp : man_resp;
    assign mem_rdata    = mem_auto ? model_rdata : man_rdata;

    mem_req_sequencer #(
        .ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_response(mem_response), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory model: answers a strobe that has been seen on mem_lat negedges.
    initial begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'hA000_0000 + 32'(i);
        model_resp  = 0;
        model_rdata = 0;
        forever begin
            @(negedge clk);
            if (mem_auto && !model_resp && (mem_wr || mem_rd)) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    model_resp  = 1;
                    model_rdata = mem_rd ? mem_model[mem_addr] : 32'h0;
                    if (mem_wr) mem_model[mem_addr] = mem_wdata;
                    cnt = 0;
                end
            end else begin
                model_resp = 0;
                cnt = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
        int n;
        n = 0;
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL push_accept: req_ready=%b, required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_rsp(output bit got);
        int n;
        n = 0;
        got = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = rsp_valid;
    endtask

    task automatic handshake();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({req_ready, rsp_valid, mem_wr, mem_rd, busy, rsp_err, rsp_write} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 1000000",
                     {req_ready, rsp_valid, mem_wr, mem_rd, busy, rsp_err, rsp_write});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0", {mem_addr, mem_wdata, rsp_rdata});
        end
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        push(1'b1, 8'h10, 32'hDEADBEEF);
        n_checks++;
        if (mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL wr_early: mem_wr=%b, required 0", mem_wr);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {2'b10, 8'h10, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL wr_strobe: got %b %b %h %h, required 1 0 10 deadbeef",
                     mem_wr, mem_rd, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, mem_wr} !== {3'b110, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_rsp: got v=%b w=%b e=%b d=%h wr=%b, required 1 1 0 0 0",
                     rsp_valid, rsp_write, rsp_err, rsp_rdata, mem_wr);
        end
        handshake();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL wr_rsp_clear: rsp_valid=%b, required 0", rsp_valid);
        end
        push(1'b0, 8'h10, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({mem_wr, mem_rd, mem_addr} !== {2'b01, 8'h10}) begin
            n_fail++;
            $display("FAIL rd_strobe: got %b %b %h, required 0 1 10", mem_wr, mem_rd, mem_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, mem_rd} !== {3'b100, 32'hDEADBEEF, 1'b0})
        begin
            n_fail++;
            $display("FAIL rd_rsp: got v=%b w=%b e=%b d=%h rd=%b, required 1 0 0 deadbeef 0",
                     rsp_valid, rsp_write, rsp_err, rsp_rdata, mem_rd);
        end
        handshake();
    endtask

    task automatic test_fill();
        bit got;
        for (int i = 0; i < 5; i++) push(1'b0, 8'(i), 32'h0);
        n_checks++;
        if ({req_ready, busy} !== 2'b01) begin
            n_fail++; $display("FAIL fill_full: ready,busy=%b, required 01", {req_ready, busy});
        end
        // Offer a sixth request while full; it must not be taken.
        req_valid = 1; req_write = 0; req_addr = 8'h3F;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++; $display("FAIL fill_hold: req_ready=%b, required 0", req_ready);
        end
        req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(got);
            n_checks++;
            if (!got || rsp_rdata !== 32'hA000_0000 + 32'(i) || rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_order[%0d]: got v=%b d=%h e=%b, required 1 %h 0",
                         i, got, rsp_rdata, rsp_err, 32'hA000_0000 + 32'(i));
            end
            handshake();
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL fill_extra: valid,busy=%b, required 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_timeout();
        bit got;
        mem_auto = 0; man_resp = 0;
        push(1'b0, 8'h20, 32'h0);
        @(negedge clk);                     // ACCESS cycle 1
        repeat (15) @(negedge clk);         // end of ACCESS cycle 16 is next edge
        n_checks++;
        if ({rsp_valid, mem_rd} !== 2'b01) begin
            n_fail++; $display("FAIL to_early: valid,rd=%b, required 01", {rsp_valid, mem_rd});
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, mem_rd} !== {2'b11, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL to_rsp: got v=%b e=%b d=%h rd=%b, required 1 1 0 0",
                     rsp_valid, rsp_err, rsp_rdata, mem_rd);
        end
        man_resp = 1; man_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        man_resp = 0;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin
            n_fail++;
            $display("FAIL to_late_resp: got v=%b e=%b d=%h, required 1 1 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        handshake();
        man_resp = 1;
        @(negedge clk);
        man_resp = 0;
        n_checks++;
        if ({rsp_valid, busy, mem_rd, mem_wr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_late_idle: got %b, required 0000", {rsp_valid, busy, mem_rd, mem_wr});
        end
        mem_auto = 1;
        push(1'b0, 8'h10, 32'h0);
        wait_rsp(got);
        n_checks++;
        if (!got || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_next: got v=%b d=%h e=%b, required 1 deadbeef 0",
                     got, rsp_rdata, rsp_err);
        end
        handshake();
    endtask

    task automatic test_resp_on_timeout();
        mem_auto = 0; man_resp = 0; man_rdata = 32'h1234_5678;
        push(1'b0, 8'h30, 32'h0);
        @(negedge clk);
        repeat (15) @(negedge clk);
        man_resp = 1;                       // sampled on the ACCESS cycle 16 edge
        @(negedge clk);
        man_resp = 0;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL tie_rsp: got v=%b e=%b d=%h, required 1 0 12345678",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        handshake();
        mem_auto = 1;
    endtask

    task automatic test_backpressure();
        bit got;
        push(1'b1, 8'h40, 32'h55AA_55AA);
        push(1'b0, 8'h10, 32'h0);
        wait_rsp(got);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({got, rsp_valid, rsp_write, rsp_err, rsp_rdata, mem_wr, mem_rd, mem_addr}
                !== {4'b1110, 32'h0, 2'b00, 8'h40}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b w=%b e=%b d=%h wr=%b rd=%b a=%h",
                         i, rsp_valid, rsp_write, rsp_err, rsp_rdata, mem_wr, mem_rd, mem_addr);
            end
            @(negedge clk);
        end
        handshake();
        n_checks++;
        if ({rsp_valid, mem_rd, mem_wr} !== 3'b000) begin
            n_fail++;
            $display("FAIL bp_gap: got %b, required 000", {rsp_valid, mem_rd, mem_wr});
        end
        wait_rsp(got);
        n_checks++;
        if (!got || rsp_write !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b w=%b d=%h, required 1 0 deadbeef",
                     got, rsp_write, rsp_rdata);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        bit got;
        mem_auto = 0; man_resp = 0;
        push(1'b0, 8'h50, 32'h0);
        @(negedge clk);
        n_checks++;
        if (mem_rd !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: mem_rd=%b, required 1", mem_rd);
        end
        #2 reset = 0;
        #1;
        n_checks++;
        if ({mem_wr, mem_rd, req_ready, busy, rsp_valid} !== 5'b00100) begin
            n_fail++;
            $display("FAIL rst_async: got %b, required 00100",
                     {mem_wr, mem_rd, req_ready, busy, rsp_valid});
        end
        @(negedge clk);
        reset = 1;
        mem_auto = 1;
        @(negedge clk);
        push(1'b0, 8'h10, 32'h0);
        wait_rsp(got);
        n_checks++;
        if (!got || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: got v=%b d=%h e=%b, required 1 deadbeef 0",
                     got, rsp_rdata, rsp_err);
        end
        handshake();
    endtask

    initial begin
        reset = 0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 0;
        mem_auto = 1; mem_lat = 1; man_resp = 0; man_rdata = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_fill();
        test_timeout();
        test_resp_on_timeout();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
